// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch-stage bus: imem request/response, decode handshake, redirect and halt
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 16
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [15:0]         imem_rdata;
    logic                instr_valid;
    logic                instr_ack;
    logic [3:0]          opcode;
    logic [3:0]          rs;
    logic [3:0]          rt;
    logic [3:0]          rd;
    logic [11:0]         imm12;
    logic [PC_WIDTH-1:0] pc_out;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                halt;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output instr_valid, opcode, rs, rt, rd, imm12, pc_out,
        input  instr_ack, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  instr_valid, opcode, rs, rt, rd, imm12, pc_out,
        output instr_ack, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/IR fetch stage with local jump resolution; PREFETCH_EN adds a one-entry prefetch buffer
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALTED} state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pc_out;
    logic [15:0]         r_ir;

    logic                w_is_jump;
    logic [PC_WIDTH-1:0] w_jump_pc;
    logic [PC_WIDTH-1:0] w_pc_inc;

    assign w_is_jump = (r_ir[15:12] == 4'b0000);
    assign w_jump_pc = {r_pc_out[PC_WIDTH-1:12], r_ir[11:0]};
    assign w_pc_inc  = r_pc + PC_WIDTH'(1);

`ifdef PREFETCH_EN
    logic [15:0] r_pbuf;
    logic        r_pbuf_valid;
    logic        w_pf_req;
    logic        w_pf_take;

    // Only one entry, so stop asking once it is full; halt also stops speculative fetches.
    assign w_pf_req  = (r_state == S_HOLD) && !r_pbuf_valid && !bus.halt;
    assign w_pf_take = w_pf_req && bus.imem_ready && !bus.redirect;
    assign bus.imem_req = !i_reset && ((r_state == S_REQ) || w_pf_req);
`else
    assign bus.imem_req = !i_reset && (r_state == S_REQ);
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (r_state == S_HOLD);
    assign bus.pc_out      = r_pc_out;
    assign bus.opcode      = r_ir[15:12];
    assign bus.rs          = r_ir[11:8];
    assign bus.rt          = r_ir[7:4];
    assign bus.rd          = r_ir[3:0];
    assign bus.imm12       = r_ir[11:0];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_pc_out <= RESET_PC;
            r_ir     <= '0;
`ifdef PREFETCH_EN
            r_pbuf       <= '0;
            r_pbuf_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.redirect) begin
                        r_pc <= bus.redirect_pc;
                    end else if (bus.imem_ready) begin
                        r_ir     <= bus.imem_rdata;
                        r_pc_out <= r_pc;
                        r_pc     <= w_pc_inc;
                        r_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
`ifdef PREFETCH_EN
                    if (bus.redirect) begin
                        r_pc         <= bus.redirect_pc;
                        r_pbuf_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end else if (bus.instr_ack) begin
                        if (w_is_jump) begin
                            r_pc         <= w_jump_pc;
                            r_pbuf_valid <= 1'b0;
                            r_state      <= bus.halt ? S_HALTED : S_REQ;
                        end else if (bus.halt) begin
                            // Rewind past the discarded prefetched word so it is refetched after halt.
                            if (r_pbuf_valid) r_pc <= r_pc - PC_WIDTH'(1);
                            r_pbuf_valid <= 1'b0;
                            r_state      <= S_HALTED;
                        end else if (r_pbuf_valid) begin
                            r_ir         <= r_pbuf;
                            r_pc_out     <= r_pc - PC_WIDTH'(1);
                            r_pbuf_valid <= 1'b0;
                        end else if (w_pf_take) begin
                            r_ir     <= bus.imem_rdata;
                            r_pc_out <= r_pc;
                            r_pc     <= w_pc_inc;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end else if (w_pf_take) begin
                        r_pbuf       <= bus.imem_rdata;
                        r_pbuf_valid <= 1'b1;
                        r_pc         <= w_pc_inc;
                    end
`else
                    if (bus.redirect) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= S_REQ;
                    end else if (bus.instr_ack) begin
                        if (w_is_jump) r_pc <= w_jump_pc;
                        r_state <= bus.halt ? S_HALTED : S_REQ;
                    end
`endif
                end
                S_HALTED: begin
                    if (!bus.halt) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(16)) bus0 ();
    instr_fetch_unit_if #(.PC_WIDTH(16)) bus1 ();

    instr_fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut0 (.i_clock(clk), .i_reset(rst0), .bus(bus0));
    instr_fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dut1 (.i_clock(clk), .i_reset(rst1), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        redirect;
        logic [15:0] redirect_pc;
        logic        ready;
        logic [15:0] rdata;
        logic        ack;
        logic        halt;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_ir;
        logic [15:0] exp_pc_out;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic [15:0] rpc, input logic rdy, input logic [15:0] rdat,
                       input logic ack, input logic hlt, input logic e_req, input logic [15:0] e_addr,
                       input logic e_val, input logic [15:0] e_ir, input logic [15:0] e_pco);
        vec_t v;
        v.redirect = rd; v.redirect_pc = rpc; v.ready = rdy; v.rdata = rdat; v.ack = ack; v.halt = hlt;
        v.exp_req = e_req; v.exp_addr = e_addr; v.exp_valid = e_val; v.exp_ir = e_ir; v.exp_pc_out = e_pco;
        vq.push_back(v);
    endtask

    task automatic idle0();
        bus0.redirect = 1'b0; bus0.redirect_pc = '0; bus0.imem_ready = 1'b0;
        bus0.imem_rdata = '0; bus0.instr_ack = 1'b0; bus0.halt = 1'b0;
    endtask

    task automatic idle1();
        bus1.redirect = 1'b0; bus1.redirect_pc = '0; bus1.imem_ready = 1'b0;
        bus1.imem_rdata = '0; bus1.instr_ack = 1'b0; bus1.halt = 1'b0;
    endtask

    initial begin
        idle0();
        idle1();
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk); #1;
        check("rst_req0", {31'd0, bus0.imem_req}, 32'd0);
        check("rst_req1", {31'd0, bus1.imem_req}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

`ifndef PREFETCH_EN
        //  rd  rpc       rdy rdata     ack hlt  req addr      val ir        pc_out
        add(0, 16'h0000, 1, 16'h1234, 0, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < 5; k++)
            add(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 16'h1234, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 1, 0,   0, 16'h0001, 1, 16'h1234, 16'h0000);
        add(0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0001, 0, 16'h1234, 16'h0000);
        add(0, 16'h0000, 1, 16'h5A3C, 0, 0,   1, 16'h0001, 0, 16'h1234, 16'h0000);
        add(1, 16'h1005, 0, 16'h0000, 1, 0,   0, 16'h0002, 1, 16'h5A3C, 16'h0001);
        add(0, 16'h0000, 1, 16'h0ABC, 0, 0,   1, 16'h1005, 0, 16'h5A3C, 16'h0001);
        add(0, 16'h0000, 0, 16'h0000, 1, 0,   0, 16'h1006, 1, 16'h0ABC, 16'h1005);
        add(1, 16'h0040, 1, 16'h7777, 0, 0,   1, 16'h1ABC, 0, 16'h0ABC, 16'h1005);
        add(0, 16'h0000, 1, 16'h8001, 0, 0,   1, 16'h0040, 0, 16'h0ABC, 16'h1005);
        add(1, 16'h0040, 0, 16'h0000, 1, 0,   0, 16'h0041, 1, 16'h8001, 16'h0040);
        add(0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0040, 0, 16'h8001, 16'h0040);
        add(0, 16'h0000, 1, 16'h0F00, 0, 0,   1, 16'h0040, 0, 16'h8001, 16'h0040);
        add(0, 16'h0000, 0, 16'h0000, 1, 1,   0, 16'h0041, 1, 16'h0F00, 16'h0040);
        add(1, 16'h2222, 0, 16'h0000, 0, 1,   0, 16'h0F00, 0, 16'h0F00, 16'h0040);
        add(0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h0F00, 0, 16'h0F00, 16'h0040);
        add(0, 16'h0000, 1, 16'h3456, 0, 0,   1, 16'h0F00, 0, 16'h0F00, 16'h0040);
        add(0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h0F01, 1, 16'h3456, 16'h0F00);
        add(0, 16'h0000, 0, 16'h0000, 1, 0,   0, 16'h0F01, 1, 16'h3456, 16'h0F00);
        add(0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h0F01, 0, 16'h3456, 16'h0F00);
        add(0, 16'h0000, 1, 16'h9ABC, 0, 1,   1, 16'h0F01, 0, 16'h3456, 16'h0F00);
        add(0, 16'h0000, 0, 16'h0000, 1, 1,   0, 16'h0F02, 1, 16'h9ABC, 16'h0F01);
        add(0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h0F02, 0, 16'h9ABC, 16'h0F01);
        add(0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h0F02, 0, 16'h9ABC, 16'h0F01);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus0.redirect    = vq[i].redirect;
            bus0.redirect_pc = vq[i].redirect_pc;
            bus0.imem_ready  = vq[i].ready;
            bus0.imem_rdata  = vq[i].rdata;
            bus0.instr_ack   = vq[i].ack;
            bus0.halt        = vq[i].halt;
            #1;
            check($sformatf("v%0d.req", i), {31'd0, bus0.imem_req}, {31'd0, vq[i].exp_req});
            check($sformatf("v%0d.addr", i), {16'd0, bus0.imem_addr}, {16'd0, vq[i].exp_addr});
            check($sformatf("v%0d.valid", i), {31'd0, bus0.instr_valid}, {31'd0, vq[i].exp_valid});
            check($sformatf("v%0d.fields", i), {16'd0, bus0.opcode, bus0.rs, bus0.rt, bus0.rd},
                  {16'd0, vq[i].exp_ir});
            check($sformatf("v%0d.imm12", i), {20'd0, bus0.imm12}, {20'd0, vq[i].exp_ir[11:0]});
            check($sformatf("v%0d.pc_out", i), {16'd0, bus0.pc_out}, {16'd0, vq[i].exp_pc_out});
        end

        // Reset forces imem_req low, then a mid-operation reset discards the held instruction.
        @(negedge clk);
        idle0();
        rst0 = 1'b1;
        #1;
        check("rst_forces_req", {31'd0, bus0.imem_req}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        bus0.imem_ready = 1'b1;
        bus0.imem_rdata = 16'h4321;
        #1;
        check("rst_addr", {16'd0, bus0.imem_addr}, 32'h0000);
        check("rst_req_after", {31'd0, bus0.imem_req}, 32'd1);
        @(negedge clk);
        bus0.imem_ready = 1'b0;
        #1;
        check("mid_valid", {31'd0, bus0.instr_valid}, 32'd1);
        check("mid_addr", {16'd0, bus0.imem_addr}, 32'h0001);
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus0.instr_valid}, 32'd0);
        check("midrst_opcode", {28'd0, bus0.opcode}, 32'd0);
        check("midrst_addr", {16'd0, bus0.imem_addr}, 32'h0000);
        check("midrst_pc_out", {16'd0, bus0.pc_out}, 32'h0000);
`endif

        // PC wrap from RESET_PC=FFFF and halt applied at ack.
        @(negedge clk);
        #1;
        check("wrap_req", {31'd0, bus1.imem_req}, 32'd1);
        check("wrap_addr", {16'd0, bus1.imem_addr}, 32'hFFFF);
        bus1.imem_ready = 1'b1;
        bus1.imem_rdata = 16'h2468;
        @(negedge clk);
        bus1.imem_ready = 1'b0;
        #1;
        check("wrap_valid", {31'd0, bus1.instr_valid}, 32'd1);
        check("wrap_pc_out", {16'd0, bus1.pc_out}, 32'hFFFF);
        check("wrap_next_addr", {16'd0, bus1.imem_addr}, 32'h0000);
        check("wrap_opcode", {28'd0, bus1.opcode}, 32'd2);
        bus1.instr_ack = 1'b1;
        bus1.halt = 1'b1;
        @(negedge clk);
        bus1.instr_ack = 1'b0;
        #1;
        check("halt_valid", {31'd0, bus1.instr_valid}, 32'd0);
        check("halt_req", {31'd0, bus1.imem_req}, 32'd0);
        check("halt_addr", {16'd0, bus1.imem_addr}, 32'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("halt_hold%0d", k), {31'd0, bus1.imem_req}, 32'd0);
        end
        @(negedge clk);
        bus1.halt = 1'b0;
        #1;
        check("unhalt_same_cycle", {31'd0, bus1.imem_req}, 32'd0);
        @(negedge clk);
        #1;
        check("unhalt_req", {31'd0, bus1.imem_req}, 32'd1);
        check("unhalt_addr", {16'd0, bus1.imem_addr}, 32'h0000);

`ifdef PREFETCH_EN
        // Back-to-back stream with ready and ack held high.
        @(negedge clk);
        idle0();
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            bus0.imem_ready = 1'b1;
            bus0.instr_ack  = 1'b1;
            bus0.imem_rdata = {4'h1, bus0.imem_addr[11:0]};
            #1;
            if (k == 0) begin
                check("pf_valid0", {31'd0, bus0.instr_valid}, 32'd0);
            end else begin
                check($sformatf("pf_valid%0d", k), {31'd0, bus0.instr_valid}, 32'd1);
                check($sformatf("pf_pc_out%0d", k), {16'd0, bus0.pc_out}, k - 1);
                check($sformatf("pf_rd%0d", k), {28'd0, bus0.rd}, k - 1);
            end
        end
        @(negedge clk);
        idle0();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
